phy_status_poller: RTL and testbench

- Autonomous MDIO (IEEE 802.3 Clause 22) read master.
- Periodically reads the 88E1111 PHY-Specific Status register (reg 17) and derives MAC speed-select signals.
- Sits directly upstream of the TSE MAC status connection: its outputs drive tse_mac_status_connection_set_10 / set_1000 of nios_system.
- Owns the board MDIO pins. The MAC's own MDIO outputs are left unconnected in the top level.

---
 rtl/phy_status_poller.sv | 246 ++++++++++++++++++++++++
 tb/tb_phy_status_poller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_status_poller.sv
// phy_status_poller: autonomous Clause 22 MDIO read master. Periodically
// reads the PHY-Specific Status register of an 88E1111 and turns the
// resolved speed/duplex/link bits into MAC speed-select outputs.
module phy_status_poller #(
    parameter int unsigned CLK_DIV       = 25,
    parameter logic [4:0]  PHY_ADDR      = 5'h10,
    parameter logic [4:0]  REG_ADDR      = 5'h11,
    parameter int unsigned POLL_INTERVAL = 5000000
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        force_poll,
    output logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oen,
    output logic        set_10,
    output logic        set_1000,
    output logic        link_up,
    output logic        duplex_full,
    output logic [15:0] status_reg,
    output logic        status_valid,
    output logic        link_change,
    output logic        phy_error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_TA,
        ST_DATA,
        ST_UPDATE
    } state_t;

    localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [31:0] POLL_LAST = 32'(POLL_INTERVAL - 1);
    // ST=01, OP=10 (read), PHY address, register address; sent MSB first
    localparam logic [13:0] HDR_BITS  = {2'b01, 2'b10, PHY_ADDR, REG_ADDR};

    // Frame bit positions (0-based, 64 MDC periods per frame)
    localparam logic [5:0] IDX_HDR_FIRST = 6'd32;
    localparam logic [5:0] IDX_TA_FIRST  = 6'd46;
    localparam logic [5:0] IDX_TA_LAST   = 6'd47;
    localparam logic [5:0] IDX_LAST      = 6'd63;

    // Pad drive for a given frame bit, returned as {oen, out}
    function automatic logic [1:0] frame_bit(input logic [5:0] idx);
        logic [3:0] hidx;
        hidx = 4'(6'd45 - idx);
        if (idx < IDX_HDR_FIRST) begin
            return 2'b01;
        end else if (idx < IDX_TA_FIRST) begin
            return {1'b0, HDR_BITS[hidx]};
        end else begin
            return 2'b11;
        end
    endfunction

    // Frame phase that owns a given bit position
    function automatic state_t phase_of(input logic [5:0] idx);
        if (idx < IDX_HDR_FIRST) begin
            return ST_PRE;
        end else if (idx < IDX_TA_FIRST) begin
            return ST_HDR;
        end else if (idx <= IDX_TA_LAST) begin
            return ST_TA;
        end else begin
            return ST_DATA;
        end
    endfunction

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [7:0]  div_q, div_d;
    logic [5:0]  bit_q, bit_d;
    logic        mdc_q, mdc_d;
    logic        mdio_out_q, mdio_out_d;
    logic        mdio_oen_q, mdio_oen_d;
    logic [15:0] shadow_q, shadow_d;
    logic        ta_bad_q, ta_bad_d;
    logic        set_10_q, set_10_d;
    logic        set_1000_q, set_1000_d;
    logic        link_up_q, link_up_d;
    logic        duplex_full_q, duplex_full_d;
    logic [15:0] status_reg_q, status_reg_d;
    logic        status_valid_q, status_valid_d;
    logic        link_change_q, link_change_d;
    logic        phy_error_q, phy_error_d;

    // Sequencing, MDC divider, serial shifting and status resolution
    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        div_d          = div_q;
        bit_d          = bit_q;
        mdc_d          = mdc_q;
        mdio_out_d     = mdio_out_q;
        mdio_oen_d     = mdio_oen_q;
        shadow_d       = shadow_q;
        ta_bad_d       = ta_bad_q;
        set_10_d       = set_10_q;
        set_1000_d     = set_1000_q;
        link_up_d      = link_up_q;
        duplex_full_d  = duplex_full_q;
        status_reg_d   = status_reg_q;
        status_valid_d = 1'b0;
        link_change_d  = 1'b0;
        phy_error_d    = phy_error_q;

        case (state_q)
            ST_IDLE: begin
                mdc_d = 1'b0;
                if (force_poll || (timer_q == POLL_LAST)) begin
                    // Start of frame: first preamble bit goes out with mdc low
                    state_d    = ST_PRE;
                    timer_d    = '0;
                    div_d      = '0;
                    bit_d      = '0;
                    shadow_d   = '0;
                    ta_bad_d   = 1'b0;
                    {mdio_oen_d, mdio_out_d} = frame_bit(6'd0);
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end

            ST_UPDATE: begin
                // A bad turnaround already raised phy_error; nothing else moves
                if (!ta_bad_q) begin
                    phy_error_d    = 1'b0;
                    status_reg_d   = shadow_q;
                    status_valid_d = 1'b1;
                    link_up_d      = shadow_q[10];
                    link_change_d  = (shadow_q[10] != link_up_q);
                    // Speed/duplex only trusted when resolved with link up
                    if (shadow_q[11] && shadow_q[10]) begin
                        case (shadow_q[15:14])
                            2'b10: begin
                                set_1000_d = 1'b1;
                                set_10_d   = 1'b0;
                            end
                            2'b01: begin
                                set_1000_d = 1'b0;
                                set_10_d   = 1'b0;
                            end
                            2'b00: begin
                                set_1000_d = 1'b0;
                                set_10_d   = 1'b1;
                            end
                            default: begin
                            end
                        endcase
                        duplex_full_d = shadow_q[13];
                    end
                end
                state_d = ST_IDLE;
                timer_d = '0;
            end

            default: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!mdc_q) begin
                        // Rising MDC: sample the PHY
                        mdc_d = 1'b1;
                        if (bit_q == IDX_TA_LAST) begin
                            if (mdio_in) begin
                                ta_bad_d    = 1'b1;
                                phy_error_d = 1'b1;
                            end
                        end else if (bit_q > IDX_TA_LAST) begin
                            shadow_d = {shadow_q[14:0], mdio_in};
                        end
                    end else begin
                        // Falling MDC: move to the next bit or finish
                        mdc_d = 1'b0;
                        if (bit_q == IDX_LAST) begin
                            state_d = ST_UPDATE;
                        end else begin
                            bit_d   = bit_q + 6'd1;
                            state_d = phase_of(bit_q + 6'd1);
                            {mdio_oen_d, mdio_out_d} = frame_bit(bit_q + 6'd1);
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
        endcase
    end

    // State registers with synchronous reset; reset also aborts a frame
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q        <= ST_IDLE;
            timer_q        <= '0;
            div_q          <= '0;
            bit_q          <= '0;
            mdc_q          <= 1'b0;
            mdio_out_q     <= 1'b1;
            mdio_oen_q     <= 1'b1;
            shadow_q       <= '0;
            ta_bad_q       <= 1'b0;
            set_10_q       <= 1'b0;
            set_1000_q     <= 1'b1;
            link_up_q      <= 1'b0;
            duplex_full_q  <= 1'b0;
            status_reg_q   <= '0;
            status_valid_q <= 1'b0;
            link_change_q  <= 1'b0;
            phy_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            div_q          <= div_d;
            bit_q          <= bit_d;
            mdc_q          <= mdc_d;
            mdio_out_q     <= mdio_out_d;
            mdio_oen_q     <= mdio_oen_d;
            shadow_q       <= shadow_d;
            ta_bad_q       <= ta_bad_d;
            set_10_q       <= set_10_d;
            set_1000_q     <= set_1000_d;
            link_up_q      <= link_up_d;
            duplex_full_q  <= duplex_full_d;
            status_reg_q   <= status_reg_d;
            status_valid_q <= status_valid_d;
            link_change_q  <= link_change_d;
            phy_error_q    <= phy_error_d;
        end
    end

    assign mdc          = mdc_q;
    assign mdio_out     = mdio_out_q;
    assign mdio_oen     = mdio_oen_q;
    assign set_10       = set_10_q;
    assign set_1000     = set_1000_q;
    assign link_up      = link_up_q;
    assign duplex_full  = duplex_full_q;
    assign status_reg   = status_reg_q;
    assign status_valid = status_valid_q;
    assign link_change  = link_change_q;
    assign phy_error    = phy_error_q;

endmodule

// File: tb/tb_phy_status_poller.sv
// Bench for phy_status_poller: a PHY model answers read frames with chosen
// register words, and a reference model predicts the status outputs.
module tb_phy_status_poller;

    localparam int CLK_DIV = 2;
    localparam int POLL    = 10;

    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic        force_poll = 1'b0;
    logic        mdio_in = 1'b1;
    logic        mdc, mdio_out, mdio_oen;
    logic        set_10, set_1000, link_up, duplex_full;
    logic [15:0] status_reg;
    logic        status_valid, link_change, phy_error;

    phy_status_poller #(
        .CLK_DIV       (CLK_DIV),
        .PHY_ADDR      (5'h10),
        .REG_ADDR      (5'h11),
        .POLL_INTERVAL (POLL)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset  (reset_reset),
        .force_poll   (force_poll),
        .mdc          (mdc),
        .mdio_in      (mdio_in),
        .mdio_out     (mdio_out),
        .mdio_oen     (mdio_oen),
        .set_10       (set_10),
        .set_1000     (set_1000),
        .link_up      (link_up),
        .duplex_full  (duplex_full),
        .status_reg   (status_reg),
        .status_valid (status_valid),
        .link_change  (link_change),
        .phy_error    (phy_error)
    );

    always #5 clk_clk = ~clk_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- PHY model ----------------
    logic [15:0] phy_resp = 16'h0000;
    logic        phy_absent = 1'b0;
    int          phy_idx = 0;       // MDC rises seen in the current frame
    int          frames_done = 0;
    logic [63:0] cap_oen = '0;
    logic [63:0] cap_out = '0;

    function automatic logic phy_bit(input int idx);
        if (phy_absent) return 1'b1;
        if (idx == 47) return 1'b0;
        if (idx >= 48 && idx <= 63) return phy_resp[63 - idx];
        return 1'b1;
    endfunction

    always @(posedge mdc or posedge reset_reset) begin
        if (reset_reset) begin
            phy_idx <= 0;
        end else begin
            cap_oen[phy_idx] <= mdio_oen;
            cap_out[phy_idx] <= mdio_out;
            if (phy_idx == 63) begin
                phy_idx     <= 0;
                frames_done <= frames_done + 1;
            end else begin
                phy_idx <= phy_idx + 1;
            end
        end
    end

    always @(negedge mdc) mdio_in <= phy_bit(phy_idx);

    // ---------------- pulse monitors ----------------
    int cnt_valid = 0;
    int cnt_change = 0;
    int both_hot = 0;
    always @(negedge clk_clk) begin
        if (status_valid) cnt_valid <= cnt_valid + 1;
        if (link_change) cnt_change <= cnt_change + 1;
        if (set_10 && set_1000) both_hot <= both_hot + 1;
    end

    // ---------------- reference model ----------------
    logic        m_set10, m_set1000, m_link, m_dup, m_err;
    logic [15:0] m_status;

    task automatic model_reset();
        m_set10 = 0; m_set1000 = 1; m_link = 0; m_dup = 0; m_err = 0; m_status = 16'h0;
    endtask

    task automatic model_frame(input logic [15:0] w, input logic absent,
                               output int exp_v, output int exp_c);
        exp_v = 0;
        exp_c = 0;
        if (absent) begin
            m_err = 1;
            return;
        end
        m_err    = 0;
        m_status = w;
        exp_v    = 1;
        exp_c    = (w[10] != m_link) ? 1 : 0;
        m_link   = w[10];
        if (w[11] && w[10]) begin
            if (w[15:14] == 2'b10) begin m_set1000 = 1; m_set10 = 0; end
            else if (w[15:14] == 2'b01) begin m_set1000 = 0; m_set10 = 0; end
            else if (w[15:14] == 2'b00) begin m_set1000 = 0; m_set10 = 1; end
            m_dup = w[13];
        end
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_mdc"}, mdc, 0);
        chk({pfx, "_mdio_out"}, mdio_out, 1);
        chk({pfx, "_mdio_oen"}, mdio_oen, 1);
        chk({pfx, "_set_10"}, set_10, 0);
        chk({pfx, "_set_1000"}, set_1000, 1);
        chk({pfx, "_link_up"}, link_up, 0);
        chk({pfx, "_duplex"}, duplex_full, 0);
        chk({pfx, "_status_reg"}, status_reg, 0);
        chk({pfx, "_status_valid"}, status_valid, 0);
        chk({pfx, "_link_change"}, link_change, 0);
        chk({pfx, "_phy_error"}, phy_error, 0);
    endtask

    // Wait for the current/next frame to finish, then for its update cycle
    task automatic wait_frame(output bit ok);
        int f0;
        int n;
        f0 = frames_done;
        n  = 0;
        while (frames_done == f0 && n < 2000) begin
            @(negedge clk_clk);
            n++;
        end
        ok = (frames_done != f0);
        repeat (4) @(negedge clk_clk);
    endtask

    task automatic check_frame(input string pfx, input logic [15:0] w, input logic absent);
        int v0, c0, ev, ec;
        bit ok;
        v0 = cnt_valid;
        c0 = cnt_change;
        phy_resp   = w;
        phy_absent = absent;
        wait_frame(ok);
        chk({pfx, "_frame_done"}, ok, 1);
        model_frame(w, absent, ev, ec);
        chk({pfx, "_status_reg"}, status_reg, m_status);
        chk({pfx, "_set_10"}, set_10, m_set10);
        chk({pfx, "_set_1000"}, set_1000, m_set1000);
        chk({pfx, "_link_up"}, link_up, m_link);
        chk({pfx, "_duplex"}, duplex_full, m_dup);
        chk({pfx, "_phy_error"}, phy_error, m_err);
        chk({pfx, "_valid_pulses"}, cnt_valid - v0, ev);
        chk({pfx, "_change_pulses"}, cnt_change - c0, ec);
    endtask

    initial begin
        int n;
        int v0;
        logic [45:0] ser;
        logic [63:0] exp_out;
        logic [15:0] w;
        logic        absent;

        model_reset();
        phy_resp = 16'hAC00;
        repeat (3) @(negedge clk_clk);
        chk_reset_vals("rst");

        // First frame arrives after the poll interval
        reset_reset = 0;
        n = 0;
        while (!mdc && n < 100) begin
            @(posedge clk_clk);
            #1;
            n++;
        end
        chk("first_mdc_rise_window", (n >= 11 && n <= 13), 1);

        check_frame("f1000", 16'hAC00, 0);
        ser = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'h10, 5'h11};
        exp_out = '0;
        for (int i = 0; i < 46; i++) exp_out[i] = ser[45 - i];
        chk("tx_bits", {18'h0, cap_out[45:0]}, exp_out);
        chk("tx_oen", cap_oen, {18'h3FFFF, 46'h0});

        check_frame("f10", 16'h0C00, 0);
        check_frame("flinkdown", 16'h4800, 0);
        check_frame("nophy", 16'hFFFF, 1);
        check_frame("f100", 16'h6C00, 0);

        // force_poll while idle with timer at 3
        phy_resp   = 16'hEC00;
        phy_absent = 0;
        repeat (2) @(negedge clk_clk);
        force_poll = 1;
        @(negedge clk_clk);
        force_poll = 0;
        chk("force_start_oen", mdio_oen, 0);
        chk("force_start_mdc", mdc, 0);

        // force_poll during the data phase is ignored
        n = 0;
        while (phy_idx < 52 && n < 2000) begin
            @(negedge clk_clk);
            n++;
        end
        force_poll = 1;
        @(negedge clk_clk);
        force_poll = 0;
        check_frame("forced", 16'hEC00, 0);
        n = 0;
        while (mdio_oen && n < 100) begin
            @(negedge clk_clk);
            n++;
        end
        chk("force_not_queued", n >= 5, 1);

        // Reset in the middle of data bit 8
        n = 0;
        while (phy_idx < 56 && n < 2000) begin
            @(negedge clk_clk);
            n++;
        end
        v0 = cnt_valid;
        reset_reset = 1;
        @(negedge clk_clk);
        chk_reset_vals("midrst");
        reset_reset = 0;
        model_reset();
        repeat (3) @(negedge clk_clk);
        chk("midrst_no_valid", cnt_valid - v0, 0);

        // Randomized frames
        for (int k = 0; k < 14; k++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 2) != 0) w[11:10] = 2'b11;
            absent = ($urandom_range(0, 4) == 0);
            check_frame("rand", w, absent);
        end

        chk("never_both_speeds", both_hot, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
